// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic ops plus iterative shift-add multiply
// and restoring divide, sequenced by an IDLE/RUN/DONE controller.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             div0_o
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             div0_q, div0_d;

  logic [SHW-1:0]   amt;
  logic             is_mul, is_div, is_sgn, is_d0;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] alu_r;

  assign amt    = src1_i[SHW-1:0];
  assign is_mul = (ctrl_i == 4'd5) || (ctrl_i == 4'd14);
  assign is_div = (ctrl_i == 4'd12) || (ctrl_i == 4'd13);
  assign is_sgn = (ctrl_i == 4'd5) || (ctrl_i == 4'd12);
  assign is_d0  = is_div && (src2_i == '0);
  assign a_neg  = is_sgn && src1_i[WIDTH-1];
  assign b_neg  = is_sgn && src2_i[WIDTH-1];
  assign a_mag  = a_neg ? -src1_i : src1_i;
  assign b_mag  = b_neg ? -src2_i : src2_i;

  always_comb begin
    alu_r = '0;
    case (ctrl_i)
      4'd0:    alu_r = src1_i & src2_i;
      4'd1:    alu_r = src1_i | src2_i;
      4'd2:    alu_r = src1_i + src2_i;
      4'd3:    alu_r = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
      4'd4:    alu_r = {{(WIDTH-1){1'b0}},
                        $signed(src1_i) < $signed(src2_i)};
      4'd6:    alu_r = src1_i - src2_i;
      4'd7:    alu_r = src1_i ^ src2_i;
      4'd8:    alu_r = $signed(src2_i) >>> amt;
      4'd9:    alu_r = src2_i >> amt;
      4'd10:   alu_r = src2_i << amt;
      4'd11:   alu_r = src2_i << (WIDTH/2);
      4'd15:   alu_r = ~(src1_i | src2_i);
      default: alu_r = '0;
    endcase
  end

  // One iteration step: multiply keeps {acc,lo} as the shifting product,
  // divide keeps acc as partial remainder and lo as dividend/quotient.
  logic             op_mul;
  logic [WIDTH:0]   sum, t, diff;
  logic             ge;
  logic [WIDTH-1:0] s_acc, s_lo;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0] q_f, r_f, fin_res, fin_hi;

  assign op_mul = (op_q == 4'd5) || (op_q == 4'd14);
  assign sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign t      = {acc_q, lo_q[WIDTH-1]};
  assign diff   = t - {1'b0, b_q};
  assign ge     = ~diff[WIDTH];
  assign s_acc  = op_mul ? sum[WIDTH:1]
                         : (ge ? diff[WIDTH-1:0] : t[WIDTH-1:0]);
  assign s_lo   = op_mul ? {sum[0], lo_q[WIDTH-1:1]}
                         : {lo_q[WIDTH-2:0], ge};
  assign prod   = {s_acc, s_lo};
  assign prod_f = nq_q ? -prod : prod;
  assign q_f    = nq_q ? -s_lo : s_lo;
  assign r_f    = nr_q ? -s_acc : s_acc;
  assign fin_res = op_mul ? prod_f[WIDTH-1:0] : q_f;
  assign fin_hi  = op_mul ? prod_f[2*WIDTH-1:WIDTH] : r_f;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    div0_d  = div0_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    if (flush_i) begin
      st_d  = IDLE;
      cnt_d = '0;
    end else begin
      case (st_q)
        RUN: begin
          acc_d  = s_acc;
          lo_d   = s_lo;
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
          if (cnt_q == CW'(1)) begin
            st_d    = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            res_d   = fin_res;
            hi_d    = fin_hi;
            zero_d  = (fin_res == '0);
            div0_d  = 1'b0;
          end
        end
        default: begin
          st_d = IDLE;
          if (start_i) begin
            op_d = ctrl_i;
            if (is_mul || (is_div && !is_d0)) begin
              st_d   = RUN;
              cnt_d  = CW'(WIDTH);
              busy_d = 1'b1;
              acc_d  = '0;
              b_d    = is_mul ? a_mag : b_mag;
              lo_d   = is_mul ? b_mag : a_mag;
              nq_d   = a_neg ^ b_neg;
              nr_d   = a_neg;
            end else begin
              st_d    = DONE;
              valid_d = 1'b1;
              res_d   = is_d0 ? '1 : alu_r;
              hi_d    = is_d0 ? src1_i : '0;
              zero_d  = is_d0 ? 1'b0 : (alu_r == '0);
              div0_d  = is_d0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      div0_q  <= div0_d;
    end
  end

  assign result_o = res_q;
  assign hi_o     = hi_q;
  assign zero_o   = zero_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign div0_o   = div0_q;
endmodule

// File: tb/tb_alu_mc.sv
// Randomized bench for alu_mc with a cycle-indexed behavioural model
// and a per-cycle comparison of every output.
module tb_alu_mc;
  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [3:0]    ctrl_i = '0;
  logic [W-1:0]  src1_i = '0;
  logic [W-1:0]  src2_i = '0;
  logic [W-1:0]  result_o, hi_o;
  logic          zero_o, valid_o, busy_o, div0_o;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .flush_i(flush_i), .ctrl_i(ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i),
    .result_o(result_o), .hi_o(hi_o), .zero_o(zero_o),
    .valid_o(valid_o), .busy_o(busy_o), .div0_o(div0_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         due;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic       d0;
  } exp_t;

  exp_t         q[$];
  int           ncyc = 0;
  int           bl = 1;
  int           bh = 0;
  logic [W-1:0] h_res = '0;
  logic [W-1:0] h_hi = '0;
  logic         h_z = 1'b1;
  logic         h_d0 = 1'b0;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, ncyc, act, exp);
    end
  endtask

  // Reference: what each op must produce, from plain wide arithmetic.
  function automatic void ref_op(input logic [3:0] c,
                                 input logic [W-1:0] a, b,
                                 output logic [W-1:0] r, h,
                                 output logic d0, output bit it);
    logic [63:0] p;
    longint sa, sb;
    r = '0; h = '0; d0 = 1'b0; it = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = (a < b) ? 1 : 0;
      4'd4: r = (sa < sb) ? 1 : 0;
      4'd5: begin p = sa * sb; r = p[31:0]; h = p[63:32]; it = 1; end
      4'd6: r = a - b;
      4'd7: r = a ^ b;
      4'd8: r = $signed(b) >>> a[4:0];
      4'd9: r = b >> a[4:0];
      4'd10: r = b << a[4:0];
      4'd11: r = b << 16;
      4'd12: begin
        if (b == 0) begin r = '1; h = a; d0 = 1; end
        else begin
          p = sa / sb; r = p[31:0];
          p = sa % sb; h = p[31:0]; it = 1;
        end
      end
      4'd13: begin
        if (b == 0) begin r = '1; h = a; d0 = 1; end
        else begin r = a / b; h = a % b; it = 1; end
      end
      4'd14: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0]; h = p[63:32]; it = 1;
      end
      default: r = ~(a | b);
    endcase
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    logic ev, eb;
    ncyc++;
    eb = (ncyc >= bl) && (ncyc <= bh);
    ev = 1'b0;
    if (q.size() > 0 && q[0].due == ncyc) begin
      e = q.pop_front();
      ev = 1'b1;
      h_res = e.res;
      h_hi = e.hi;
      h_z = (e.res == '0);
      h_d0 = e.d0;
    end
    chk("valid", {31'b0, valid_o}, {31'b0, ev});
    chk("busy", {31'b0, busy_o}, {31'b0, eb});
    chk("result", result_o, h_res);
    chk("hi", hi_o, h_hi);
    chk("zero", {31'b0, zero_o}, {31'b0, h_z});
    chk("div0", {31'b0, div0_o}, {31'b0, h_d0});
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic drive(input bit st, input bit fl, input logic [3:0] ct,
                       input logic [W-1:0] a, b);
    int c;
    logic [W-1:0] r, h;
    logic d0;
    bit it;
    exp_t e;
    c = ncyc + 1;
    start_i = st;
    flush_i = fl;
    ctrl_i = ct;
    src1_i = a;
    src2_i = b;
    if (fl) begin
      while (q.size() > 0 && q[q.size()-1].due > c) void'(q.pop_back());
      if (bh > c) bh = c;
    end else if (st && !(c >= bl && c <= bh)) begin
      ref_op(ct, a, b, r, h, d0, it);
      e.due = c + (it ? W + 1 : 1);
      e.res = r; e.hi = h; e.d0 = d0;
      q.push_back(e);
      if (it) begin bl = c + 1; bh = c + W; end
    end
  endtask

  task automatic drive_lit(input logic [3:0] ct, input logic [W-1:0] a, b,
                           input logic [W-1:0] er, eh, input logic ed);
    logic [W-1:0] r, h;
    logic d0;
    bit it;
    ref_op(ct, a, b, r, h, d0, it);
    chk("pin_res", r, er);
    chk("pin_hi", h, eh);
    chk("pin_d0", {31'b0, d0}, {31'b0, ed});
    drive(1, 0, ct, a, b);
    if (q.size() > 0) begin
      q[q.size()-1].res = er;
      q[q.size()-1].hi = eh;
      q[q.size()-1].d0 = ed;
    end
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 100 && (q.size() > 0 || ncyc + 1 <= bh); i++)
      tick();
  endtask

  task automatic do_reset;
    rst_i = 1'b0;
    q.delete();
    bl = 1; bh = 0;
    h_res = '0; h_hi = '0; h_z = 1'b1; h_d0 = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    drive_lit(4'd2, 32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFE, 0, 0);
    tick();
    wait_idle();
    drive_lit(4'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 5; i++) tick();
    drive(1, 0, 4'd6, 32'd3, 32'd3);
    while (ncyc + 1 < bh + 1) tick();
    drive_lit(4'd6, 32'd3, 32'd3, 0, 0, 0);
    tick();
    wait_idle();
    drive_lit(4'd14, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 0);
    tick();
    wait_idle();
    drive_lit(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    tick();
    wait_idle();
    drive_lit(4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
    tick();
    wait_idle();
    drive_lit(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    tick();
    wait_idle();
    drive_lit(4'd11, 0, 32'h0000_ABCD, 32'hABCD_0000, 0, 0);
    tick();
    wait_idle();
    drive(1, 0, 4'd5, 32'd1234, 32'd99);
    for (int i = 0; i < 10; i++) tick();
    drive(1, 1, 4'd2, 32'd1, 32'd1);
    tick();
    wait_idle();
    drive(1, 0, 4'd13, 32'd1000, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    for (int n = 0; n < 3000; n++) begin
      int r;
      tick();
      r = $urandom_range(0, 299);
      if (r == 0) do_reset();
      else drive(r < 140, r >= 290, 4'($urandom_range(0, 15)),
                 rnd_op(), rnd_op());
    end
    tick();
    wait_idle();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
